adder_pipe: RTL
===============

ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (>= 2).
REQ-002 SHALL have parameter SEG, default 4, carry-segment width; WIDTH multiple of SEG; STAGES = WIDTH/SEG.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand set a/b/mode presented.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A, unsigned, or two's-complement for ovf.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port mode  input  1  0 = add, 1 = subtract (a - b).
REQ-010 SHALL have port out_valid  output  1  result on out/ovf is valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out  output  WIDTH+1  result; MSB = carry (add) or borrow (sub).
REQ-013 SHALL have port ovf  output  1  signed two's-complement overflow of the operation.

Function
REQ-014 SHALL implement a STAGES-deep pipeline; stage k adds bits [k*SEG+SEG-1 : k*SEG] with the carry registered from stage k-1.
REQ-015 SHALL implement subtract as a + ~b with carry-in 1; out[WIDTH] = NOT final carry, so 1 iff a < b unsigned.
REQ-016 SHALL implement add as out = a + b zero-extended to WIDTH+1 bits; no truncation.
REQ-017 SHALL set ovf = 1 iff operand sign bits (b inverted for sub) are equal and result bit WIDTH-1 differs from them.
REQ-018 SHALL carry not-yet-added upper operand slices and mode alongside the partial result so each stage consumes only its own slice.
REQ-019 SHALL use a global advance = !out_valid || out_ready; all stage registers and valid bits move only when advance = 1.
REQ-020 SHALL drive in_ready = advance (combinational) and accept an operand set on in_valid && in_ready.
REQ-021 SHALL insert a bubble (valid = 0) into stage 0 when advance = 1 and in_valid = 0.
REQ-022 SHALL hold out, ovf and out_valid stable while out_valid = 1 and out_ready = 0 (full stall; no operand lost or duplicated).
REQ-023 SHALL have latency exactly STAGES cycles from acceptance to out_valid when no stall occurs; throughput one result per cycle.
REQ-024 SHALL deliver results strictly in acceptance order; bubbles compress only when downstream stalls.
REQ-025 SHALL be correct at wrap-around extremes: all-ones + all-ones, 0 - 0, 0 - 1 (borrow 1, low bits all ones).
REQ-026 SHALL treat simultaneous output consumption and input acceptance as one advance: no cycle loss at full throughput.

Reset
REQ-027 SHALL, on a rising clk edge with rst_n = 0, clear all valid bits, out to 0 and ovf to 0, regardless of in_valid/out_ready.
REQ-028 SHALL flush in-flight operations on reset mid-operation; none appear on out after rst_n returns high.
REQ-029 SHALL drive in_ready = 1 in the first cycle after reset release (pipeline empty).

Verification (WIDTH=8, SEG=4, latency 2, out_ready=1 unless stated)
REQ-030 SHALL pass: add 108+82, 237+114, 175+82, 253+66 on consecutive cycles -> out = 190, 351, 257, 319 on four consecutive cycles starting 2 cycles after the first.
REQ-031 SHALL pass: sub 82-108 -> out = 9'h1E6 (borrow 1, low 230), ovf 0; sub 8'h80-8'h01 -> out = 9'h07F, ovf 1.
REQ-032 SHALL pass: add 8'h7F+8'h01 -> out = 9'h080, ovf 1; add 8'hFF+8'hFF -> out = 9'h1FE, ovf 0.
REQ-033 SHALL pass: stream 3 operations, hold out_ready = 0 for 5 cycles once out_valid rises -> in_ready low, out frozen, all 3 results later delivered in order once released.
REQ-034 SHALL pass: accept 2 operations, assert rst_n = 0 one cycle -> out_valid 0, out 0, no result emerges afterwards.
REQ-035 SHALL pass: repeat REQ-030 with WIDTH=16, SEG=4 -> same sums, latency 4.

Source files
------------

// File: rtl/adder_pipe.sv
// Segmented carry pipeline adder/subtractor with a valid/ready stream interface.
// Each stage adds one SEG-bit slice and hands its carry and the untouched operand slices to the next.

module adder_pipe_seg #(
  parameter int SEG = 4,
  parameter int LO  = 0,
  parameter int REM = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    adv,
  input  logic [LO:0]             prev_res,
  input  logic [2*(REM+SEG)+2:0]  prev_ops,
  output logic [LO+SEG:0]         res,
  output logic [2*REM+2:0]        ops
);
  localparam int AW = REM + SEG;

  // prev_ops = {a_rem, b_rem, sign_a, sign_b_eff, mode}; prev_res = {carry, partial sum}
  logic [AW-1:0]     a_rem, b_rem;
  logic [2:0]        ctl;
  logic              cin;
  logic [SEG:0]      part;
  logic [LO+SEG:0]   res_nxt;
  logic [2*REM+2:0]  ops_nxt;

  assign a_rem = prev_ops[2*AW+2:AW+3];
  assign b_rem = prev_ops[AW+2:3];
  assign ctl   = prev_ops[2:0];
  assign cin   = prev_res[LO];
  assign part  = {1'b0, a_rem[SEG-1:0]} + {1'b0, b_rem[SEG-1:0]} + {{SEG{1'b0}}, cin};

  if (LO > 0) begin : g_acc
    assign res_nxt = {part, prev_res[LO-1:0]};
  end else begin : g_first
    assign res_nxt = part;
  end

  if (REM > 0) begin : g_rem
    assign ops_nxt = {a_rem[AW-1:SEG], b_rem[AW-1:SEG], ctl};
  end else begin : g_last
    assign ops_nxt = ctl;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res <= '0;
      ops <= '0;
    end else if (adv) begin
      res <= res_nxt;
      ops <= ops_nxt;
    end
  end
endmodule

module adder_pipe #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             ovf
);
  localparam int STAGES = WIDTH / SEG;

  logic              adv;
  logic [STAGES-1:0] vld_q;
  logic [STAGES:0]   vld_pipe;
  logic [WIDTH-1:0]  b_eff;

  // One global advance: the whole pipe moves or the whole pipe holds.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[STAGES];
  assign b_eff     = b ^ {WIDTH{mode}};

  always_ff @(posedge clk) begin
    if (!rst_n)   vld_q <= '0;
    else if (adv) vld_q <= vld_pipe[STAGES-1:0];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SEG;
    localparam int REM = WIDTH - (k + 1) * SEG;

    logic [LO:0]              res_in;
    logic [2*(REM+SEG)+2:0]   ops_in;
    logic [LO+SEG:0]          res;
    logic [2*REM+2:0]         ops;

    if (k == 0) begin : g_head
      // Subtract is a + ~b with carry-in 1, so mode doubles as the initial carry.
      assign res_in = mode;
      assign ops_in = {a, b_eff, a[WIDTH-1], b_eff[WIDTH-1], mode};
    end else begin : g_link
      assign res_in = g_stage[k-1].res;
      assign ops_in = g_stage[k-1].ops;
    end

    adder_pipe_seg #(.SEG(SEG), .LO(LO), .REM(REM)) u_seg (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
      .prev_res (res_in),
      .prev_ops (ops_in),
      .res      (res),
      .ops      (ops)
    );

    if (k == STAGES - 1) begin : g_tail
      // Final carry is inverted into a borrow for subtract.
      assign out = {res[WIDTH] ^ ops[0], res[WIDTH-1:0]};
      assign ovf = (ops[2] == ops[1]) && (res[WIDTH-1] != ops[2]);
    end
  end
endmodule
